// File: rtl/demux_seq.sv
// Sequential 1:N demultiplexer: serial bits under valid/ready are assembled into a
// LANES-wide frame. Optional trailing even-parity bit with DEMUX_SEQ_PARITY_EN.
module demux_seq #(
  parameter int LANES = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             in_last,
  output logic [SEL_W-1:0] lane_idx,
  output logic [LANES-1:0] out_lanes,
  output logic [SEL_W:0]   out_count,
`ifdef DEMUX_SEQ_PARITY_EN
  output logic             out_perr,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [LANES-1:0] acc_reg;
  logic [SEL_W-1:0] cnt_reg;
  logic [SEL_W:0]   hold_count_reg;
  logic [LANES-1:0] out_lanes_reg;
  logic [SEL_W:0]   out_count_reg;
  logic             out_valid_reg;

  logic [LANES-1:0] merged;
  logic [SEL_W:0]   count_next;
  logic             closing;
  logic             slot_free;
  logic             xfer;

  // acc bit cnt is always zero before it is written, so OR is a write.
  assign merged     = acc_reg | (LANES'(in_bit) << cnt_reg);
  assign count_next = {1'b0, cnt_reg} + 1'b1;
  assign closing    = (cnt_reg == SEL_W'(LANES - 1)) || in_last;
  assign xfer       = out_valid_reg && out_ready;
  assign slot_free  = !out_valid_reg || out_ready;

  assign in_ready  = (state_reg == FILL) || (state_reg == PAR);
  assign lane_idx  = cnt_reg;
  assign out_lanes = out_lanes_reg;
  assign out_count = out_count_reg;
  assign out_valid = out_valid_reg;

`ifdef DEMUX_SEQ_PARITY_EN
  logic out_perr_reg;
  logic hold_perr_reg;
  logic par_err;

  assign par_err  = (^acc_reg) ^ in_bit;
  assign out_perr = out_perr_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FILL;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      hold_count_reg <= '0;
      out_lanes_reg  <= '0;
      out_count_reg  <= '0;
      out_valid_reg  <= 1'b0;
`ifdef DEMUX_SEQ_PARITY_EN
      out_perr_reg   <= 1'b0;
      hold_perr_reg  <= 1'b0;
`endif
    end else begin
      // A load below overrides this, giving bubble-free back-to-back frames.
      if (xfer) begin
        out_valid_reg <= 1'b0;
      end
      case (state_reg)
        FILL: begin
          if (in_valid) begin
            if (closing) begin
`ifdef DEMUX_SEQ_PARITY_EN
              acc_reg        <= merged;
              hold_count_reg <= count_next;
              cnt_reg        <= '0;
              state_reg      <= PAR;
`else
              if (slot_free) begin
                out_lanes_reg <= merged;
                out_count_reg <= count_next;
                out_valid_reg <= 1'b1;
                acc_reg       <= '0;
                cnt_reg       <= '0;
              end else begin
                acc_reg        <= merged;
                hold_count_reg <= count_next;
                state_reg      <= HOLD;
              end
`endif
            end else begin
              acc_reg <= merged;
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
`ifdef DEMUX_SEQ_PARITY_EN
        PAR: begin
          if (in_valid) begin
            if (slot_free) begin
              out_lanes_reg <= acc_reg;
              out_count_reg <= hold_count_reg;
              out_perr_reg  <= par_err;
              out_valid_reg <= 1'b1;
              acc_reg       <= '0;
              cnt_reg       <= '0;
              state_reg     <= FILL;
            end else begin
              hold_perr_reg <= par_err;
              state_reg     <= HOLD;
            end
          end
        end
`endif
        HOLD: begin
          if (xfer) begin
            out_lanes_reg <= acc_reg;
            out_count_reg <= hold_count_reg;
            out_valid_reg <= 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
            out_perr_reg  <= hold_perr_reg;
`endif
            acc_reg       <= '0;
            cnt_reg       <= '0;
            state_reg     <= FILL;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_seq.sv
// Scoreboard bench for demux_seq: frame-level reference model feeds a queue that a
// separate monitor drains whenever the DUT presents a frame.
module tb_demux_seq;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             in_last;
  logic [SEL_W-1:0] lane_idx;
  logic [LANES-1:0] out_lanes;
  logic [SEL_W:0]   out_count;
  logic             out_valid;
  logic             out_ready;
`ifdef DEMUX_SEQ_PARITY_EN
  logic             out_perr;
`endif

  demux_seq #(.LANES(LANES), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .in_last(in_last),
    .lane_idx(lane_idx), .out_lanes(out_lanes), .out_count(out_count),
`ifdef DEMUX_SEQ_PARITY_EN
    .out_perr(out_perr),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] lanes;
    int               count;
    bit               perr;
  } exp_t;

  exp_t sb[$];
  bit   part[$];
  bit   par_pending = 0;
  exp_t par_frame;
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 1;
  bit   watch_bubble = 0;
  int   low_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: collects accepted bits into frames by count/in_last rules.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      part.delete();
      sb.delete();
      par_pending = 0;
    end else if (in_valid && in_ready) begin
      if (par_pending) begin
        e = par_frame;
        e.perr = ((^e.lanes) != in_bit);
        sb.push_back(e);
        par_pending = 0;
      end else begin
        part.push_back(in_bit);
        if (in_last || part.size() == LANES) begin
          e.lanes = '0;
          for (int i = 0; i < part.size(); i++) e.lanes[i] = part[i];
          e.count = part.size();
          e.perr  = 0;
`ifdef DEMUX_SEQ_PARITY_EN
          par_frame   = e;
          par_pending = 1;
`else
          sb.push_back(e);
`endif
          part.delete();
        end
      end
    end
  end

  // Monitor: any presented frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        check("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("out_lanes", 32'(out_lanes), 32'(sb[0].lanes));
          check("out_count", 32'(out_count), 32'(sb[0].count));
`ifdef DEMUX_SEQ_PARITY_EN
          check("out_perr", 32'(out_perr), 32'(sb[0].perr));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (watch_bubble && !out_valid) low_cycles++;
    end
  end

  // Input side accepts only while fewer than two complete frames are undelivered.
  always @(posedge clk) begin
    #2;
    check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    if (sb.size() < 2) check("lane_idx", 32'(lane_idx), 32'(part.size()));
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input bit b, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input int n);
    bit p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      p ^= v[i];
      send(v[i], i == n - 1);
    end
`ifdef DEMUX_SEQ_PARITY_EN
    send(p, 1'b0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    time t0;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_lanes", 32'(out_lanes), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Full 8-bit frame 1,0,1,1,0,0,1,0.
    ready_mode = 1;
    send_frame(8'h4D, 8);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_lanes", 32'(out_lanes), 32'h4D);
    check("t1_count", 32'(out_count), 32'd8);

    // Short frame closed by in_last.
    send_frame(8'h07, 3);
    check("t2_lanes", 32'(out_lanes), 32'h07);
    check("t2_count", 32'(out_count), 32'd3);
    check("t2_lane_idx", 32'(lane_idx), 32'd0);
    idle(2);

    // Backpressure: second frame waits in HOLD.
    ready_mode = 0; out_ready = 1'b0;
    send_frame(8'hFF, 8);
    send_frame(8'hA5, 8);
    check("t3_hold_ready", 32'(in_ready), 32'd0);
    idle(3);
    check("t3_stable", 32'(out_lanes), 32'hFF);
    ready_mode = 1; out_ready = 1'b1;
    idle(1);
    check("t3_second", 32'(out_lanes), 32'hA5);
    check("t3_second_valid", 32'(out_valid), 32'd1);
    idle(2);

`ifndef DEMUX_SEQ_PARITY_EN
    // One-bit frames back to back: no bubble on out_valid.
    send(1'b1, 1'b1);
    low_cycles = 0;
    watch_bubble = 1;
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), 1'b1);
    watch_bubble = 0;
    check("t4_no_bubble", 32'(low_cycles), 32'd0);
    t0 = $time;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 8);
    check("t4_throughput", 32'(($time - t0) / 10), 32'd24);
    idle(2);
`endif

    // Reset mid-frame with a frame waiting in the slot.
    ready_mode = 0; out_ready = 1'b0;
    send_frame(8'hFF, 8);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_lane_idx", 32'(lane_idx), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_lanes", 32'(out_lanes), 32'd0);
    check("t5_count", 32'(out_count), 32'd0);
    ready_mode = 1; out_ready = 1'b1;
    send_frame(8'h3C, 8);
    check("t5_new_frame", 32'(out_lanes), 32'h3C);
    idle(2);

`ifdef DEMUX_SEQ_PARITY_EN
    for (int i = 0; i < 8; i++) send(i < 2, i == 7);
    send(1'b0, 1'b0);
    check("par_ok", 32'(out_perr), 32'd0);
    for (int i = 0; i < 8; i++) send(i < 2, i == 7);
    send(1'b1, 1'b0);
    check("par_err", 32'(out_perr), 32'd1);
    idle(2);
`endif

    // Randomized stream with random gaps, in_last and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
    end

    ready_mode = 1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
    idle(2);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_seq.md
Name: demux_seq

Overview:
- Sequential 1:8 demultiplexer: the receive-side counterpart of the team's 8:1 bit mux.
- Accepts a serial bit stream under valid/ready and steers each accepted bit into lane 0..7 using an internal lane counter.
- Presents the assembled 8-bit frame on a registered output with valid/ready handshake.
- Sits between a serialised link and parallel consumers.

Parameters:
- LANES, 8, number of output lanes; must be a power of two ≥ 2.
- SEL_W, 3, lane index width; must equal log2(LANES).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block accepts in_bit this cycle.
- in_last  input  1  with an accepted bit: close frame after this bit.
- lane_idx  output  SEL_W  lane the next accepted bit is written to.
- out_lanes  output  LANES  assembled frame; bit k = lane k.
- out_count  output  SEL_W+1  number of lanes written in the frame, 1..LANES.
- out_valid  output  1  frame on out_lanes/out_count is valid.
- out_ready  input  1  consumer takes the frame.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Accept rule: input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Storage: accumulator register acc[LANES-1:0], lane counter cnt[SEL_W-1:0], output register with valid flag.
- State FILL:
  - in_ready=1.
  - On accept, acc[cnt] <= in_bit and cnt increments.
  - Frame closes when cnt==LANES-1 or in_last=1.
- Frame close:
  - If the output slot is empty, or out_ready=1 in the same cycle:
    - out_lanes <= acc with the closing bit merged.
    - out_count <= cnt+1.
    - out_valid <= 1 next cycle.
    - acc <= 0, cnt <= 0; stay in FILL.
  - Otherwise go to HOLD.
- State HOLD (complete frame waiting for the output slot):
  - in_ready=0.
  - On an output transfer, load acc into the output register the same cycle, clear acc and cnt, return to FILL.
- Unwritten lanes of a short frame (in_last early) read as 0.
- Latency: closing bit accepted in cycle N → out_valid=1 in cycle N+1. Output transfer and a new close in the same cycle → out_valid stays 1 with the new frame; no bubble.
- Wrap-around: cnt wraps LANES-1 → 0 only through a frame close; never silent overwrite.
- in_ready = (state==FILL). Purely registered state; no combinational path from out_ready to in_ready.
- lane_idx = cnt.
- in_valid=0: no state change. in_last without in_valid: ignored.
- out_valid stays 1 until out_ready; out_lanes/out_count stable while out_valid & !out_ready.
- Reset (any cycle, including mid-frame or in HOLD):
  - state=FILL, cnt=0, acc=0.
  - out_valid=0, out_lanes=0, out_count=0.
  - in_ready=1 from the first cycle after reset.
  - Any partial frame is discarded.

Optional Feature:
- Macro: DEMUX_SEQ_PARITY_EN.
- With the macro defined:
  - Each frame is followed by one extra accepted bit: even parity over the data lanes written.
  - Parity bit is consumed in state PAR (in_ready=1), entered after the data close.
  - in_last is ignored on the parity bit.
  - Adds output port out_perr (1 bit), registered alongside out_lanes; 1 = parity mismatch. Reset value 0.
  - Output latency is measured from the parity bit.
- Without the macro: no PAR state, no out_perr port, behaviour exactly as above.

Test Plan:
- Reset then bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 → one cycle after the 8th bit: out_valid=1, out_lanes=8'h4D, out_count=8.
- Bits 1,1,1 with in_last on the 3rd bit → out_lanes=8'h07, out_count=3; the next frame starts at lane_idx=0.
- out_ready=0, stream 16 bits 8'hFF then 8'hA5 → first frame held stable. in_ready=0 after the second frame closes (HOLD). Raising out_ready gives 8'hFF then 8'hA5 on consecutive transfers; no data lost.
- Back-to-back frames with out_ready held 1 → out_valid stays high across frames, no bubble; throughput of 1 bit per cycle.
- rst asserted after 4 bits of a frame → next cycle cnt=0, out_valid=0, out_lanes=0. A new 8-bit frame 8'h3C is then received intact.
- DEMUX_SEQ_PARITY_EN: frame 8'h03 followed by parity bit 0 → out_perr=0. Same frame with parity bit 1 → out_perr=1.
